action_table_ctrl: RTL and testbench
====================================

// Module: action_table_ctrl
// PURPOSE
//  Owns the 1024-entry action table (single-port BRAM) and shares its one port between the
//  flow_table lookup path and the AXI4-Lite config path. Clears the table after reset.
//  Arbitrates lookup vs config per cycle with a starvation guard. Returns the action_t for a hit
//  to the downstream action/TX logic. Sits between flow_table and the AXI-Stream TX datapath.
// PARAMETERS
//  DEPTH         1024  table entries (power of 2); ADDR_W = $clog2(DEPTH)
//  STARVE_LIMIT  8     max consecutive lookup grants while a config request waits
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   async active-low reset
//  lkp_valid    in   1   lookup request (from flow_table hit)
//  lkp_ready    out  1   lookup accepted when valid&&ready
//  lkp_flow_id  in   16  flow id; index = lkp_flow_id[ADDR_W-1:0]
//  res_valid    out  1   one-cycle result strobe
//  res_hit      out  1   entry valid and flow_id matched
//  res_action   out  25  action_t of hit entry; '0 on miss
//  cfg_we       in   1   config write request, level, held until wdone
//  cfg_waddr    in   16  flow id to program; index = cfg_waddr[ADDR_W-1:0]
//  cfg_wdata    in   32  [0]drop [1]fwd [2]modify [6:3]out_port [7]trap [8]count [31]invalidate
//  cfg_wdone    out  1   one-cycle write-complete pulse
//  cfg_re       in   1   config read request, level, held until rvalid
//  cfg_raddr    in   16  read index = cfg_raddr[ADDR_W-1:0]
//  cfg_rdata    out  32  {valid, 6'b0, flow_id[15:0], wdata[8:0] layout}
//  cfg_rvalid   out  1   one-cycle read-data strobe
//  init_done    out  1   table clear finished
// BEHAVIOUR
//  Reset: all outputs 0; state=INIT; starve_cnt=0; no in-flight result survives (mid-op reset drops it).
//  INIT: write action_t '0 to index 0..DEPTH-1, one per cycle (DEPTH cycles); lkp_ready=0; cfg held
//   pending; then init_done=1 (stays 1), state=RUN.
//  RUN grant (one per cycle): lookup if lkp_valid && !(cfg_pend && starve_cnt==STARVE_LIMIT);
//   else write if cfg_we; else read if cfg_re. Write beats read when both pending.
//  lkp_ready = RUN && lookup would win arbitration this cycle (combinational).
//  starve_cnt: +1 on lookup grant while cfg_pend; clear on cfg grant or !cfg_pend; saturates.
//  Lookup accepted cycle T: BRAM read T, data T+1, compare registered; res_valid/hit/action at T+2.
//   hit = entry.valid && entry.flow_id==lkp_flow_id. Fully pipelined, one lookup per cycle.
//  Write granted T: BRAM write T of {bits from wdata, flow_id=cfg_waddr, valid=!wdata[31]};
//   cfg_wdone=1 at T+1. cfg_we ignored at T+1 (requester drops by then).
//  Read granted T: cfg_rvalid/cfg_rdata at T+2; cfg_re ignored at T+1, T+2.
//  Lookup accepted the cycle after a write to the same index returns the new entry (no hazard logic).
//  Only one config op outstanding; cfg_pend = (cfg_we|cfg_re) && not blanked.
// CONFIGURATION
//  ACTION_CTRL_READBACK_EN defined: cfg_re path as above.
//  Undefined: cfg_re ignored, never granted, cfg_rvalid=0, cfg_rdata=0; ports still present.
// STRUCTURE
//  dataplane_pkg: action_t (drop,forward,modify,out_port[3:0],trap,count,valid,flow_id[15:0]),
//   ACTION_W=25, CFG_* wdata bit-position constants, pack_cfg_wdata()/unpack_rdata() functions.
//  Sub-module action_table_ram: single-port, read-first, 1-cycle read latency, DEPTH x ACTION_W.
//  Controller FSM: INIT, RUN.
// TESTING
//  Reset release -> init_done rises after exactly 1024 cycles; lkp_ready=0 throughout INIT.
//  Write waddr=0x0105 wdata=0x00A (fwd, out_port=1) then lookup 0x0105 -> res_hit=1,
//   res_action.forward=1, out_port=1, 2 cycles after accept.
//  Lookup 0x0505 (same index 0x105, different flow_id) -> res_valid=1, res_hit=0, res_action=0.
//  Continuous lkp_valid with cfg_we held -> write granted on 9th cycle; wdone exactly once.
//  Write wdata[31]=1 to 0x0105, lookup 0x0105 -> res_hit=0; readback (READBACK_EN) rdata[31]=0.
//  Assert rst_n=0 during a lookup in flight -> no res_valid after release; INIT restarts.

Source files
------------

// File: rtl/dataplane_pkg.sv
// Shared dataplane types: the 25-bit action_t, the stored table entry (valid + action_t),
// cfg_wdata bit positions and the helpers that pack config writes and format readback words.
package dataplane_pkg;

    localparam int unsigned ACTION_W = 25;

    localparam int unsigned CFG_DROP_BIT   = 0;
    localparam int unsigned CFG_FWD_BIT    = 1;
    localparam int unsigned CFG_MODIFY_BIT = 2;
    localparam int unsigned CFG_PORT_LSB   = 3;
    localparam int unsigned CFG_PORT_W     = 4;
    localparam int unsigned CFG_TRAP_BIT   = 7;
    localparam int unsigned CFG_COUNT_BIT  = 8;
    localparam int unsigned CFG_INVAL_BIT  = 31;

    // Low 9 bits line up with cfg_wdata[8:0]; flow_id sits above them.
    typedef struct packed {
        logic [15:0] flow_id;
        logic        count;
        logic        trap;
        logic [3:0]  out_port;
        logic        modify;
        logic        forward;
        logic        drop;
    } action_t;

    // The valid flag is stored alongside action_t so res_action stays exactly ACTION_W wide.
    typedef struct packed {
        logic    valid;
        action_t action;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    function automatic entry_t pack_cfg_wdata(input logic inval, input logic [8:0] bits,
                                              input logic [15:0] flow_id);
        entry_t e;
        e.valid           = ~inval;
        e.action.flow_id  = flow_id;
        e.action.count    = bits[CFG_COUNT_BIT];
        e.action.trap     = bits[CFG_TRAP_BIT];
        e.action.out_port = bits[CFG_PORT_LSB +: CFG_PORT_W];
        e.action.modify   = bits[CFG_MODIFY_BIT];
        e.action.forward  = bits[CFG_FWD_BIT];
        e.action.drop     = bits[CFG_DROP_BIT];
        return e;
    endfunction

    function automatic logic [31:0] unpack_rdata(input entry_t e);
        return {e.valid, 6'b0, e.action};
    endfunction

endpackage

// File: rtl/action_table_ram.sv
// Single-port, read-first block RAM with one cycle of read latency; no reset on contents.
module action_table_ram
    import dataplane_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned WIDTH  = ENTRY_W,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/action_table_ctrl.sv
// Action table controller: clears the table after reset, then arbitrates the single RAM port
// between lookups and config access. Define ACTION_CTRL_READBACK_EN to enable cfg_re reads.
module action_table_ctrl
    import dataplane_pkg::*;
#(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lkp_valid,
    output logic                lkp_ready,
    input  logic [15:0]         lkp_flow_id,
    output logic                res_valid,
    output logic                res_hit,
    output logic [ACTION_W-1:0] res_action,
    input  logic                cfg_we,
    input  logic [15:0]         cfg_waddr,
    input  logic [31:0]         cfg_wdata,
    output logic                cfg_wdone,
    input  logic                cfg_re,
    input  logic [15:0]         cfg_raddr,
    output logic [31:0]         cfg_rdata,
    output logic                cfg_rvalid,
    output logic                init_done
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [1:0]        blank_q, blank_d;

    logic              re_req, cfg_pend, starved;
    logic              grant_lkp, grant_wr, grant_rd;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    entry_t            ram_wdata, ram_rdata;

    logic              lkp_s1_q, rd_s1_q;
    logic [15:0]       lkp_id_q;
    logic              entry_hit;
    logic              unused_in;

`ifdef ACTION_CTRL_READBACK_EN
    assign re_req = cfg_re;
`else
    assign re_req = 1'b0;
`endif

    assign unused_in = ^{cfg_wdata[30:9], cfg_raddr, cfg_re};

    // blank_q masks the requester's level for the cycles it takes to see the completion strobe.
    assign cfg_pend  = (cfg_we | re_req) && (blank_q == 2'd0);
    assign starved   = cfg_pend && (starve_q == CNT_W'(STARVE_LIMIT));
    assign lkp_ready = grant_lkp;
    assign init_done = (state_q == StRun);
    assign entry_hit = ram_rdata.valid && (ram_rdata.action.flow_id == lkp_id_q);

    always_comb begin
        state_d   = state_q;
        grant_lkp = 1'b0;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            StInit: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = init_cnt_q;
                if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (lkp_valid && !starved) begin
                    grant_lkp = 1'b1;
                    ram_en    = 1'b1;
                    ram_addr  = lkp_flow_id[ADDR_W-1:0];
                end else if (cfg_we && (blank_q == 2'd0)) begin
                    grant_wr  = 1'b1;
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = cfg_waddr[ADDR_W-1:0];
                    ram_wdata = pack_cfg_wdata(cfg_wdata[CFG_INVAL_BIT], cfg_wdata[8:0],
                                               cfg_waddr);
                end else if (re_req && (blank_q == 2'd0)) begin
                    grant_rd = 1'b1;
                    ram_en   = 1'b1;
                    ram_addr = cfg_raddr[ADDR_W-1:0];
                end
            end
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (state_q == StRun) begin
            if (grant_wr || grant_rd || !cfg_pend) begin
                starve_d = '0;
            end else if (grant_lkp && (starve_q != CNT_W'(STARVE_LIMIT))) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (grant_wr) begin
            blank_d = 2'd1;
        end else if (grant_rd) begin
            blank_d = 2'd2;
        end else if (blank_q != 2'd0) begin
            blank_d = blank_q - 2'd1;
        end
    end

    action_table_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            starve_q   <= '0;
            blank_q    <= '0;
            lkp_s1_q   <= 1'b0;
            lkp_id_q   <= '0;
            rd_s1_q    <= 1'b0;
            res_valid  <= 1'b0;
            res_hit    <= 1'b0;
            res_action <= '0;
            cfg_wdone  <= 1'b0;
            cfg_rvalid <= 1'b0;
            cfg_rdata  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            blank_q  <= blank_d;
            if (state_q == StInit) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
            lkp_s1_q <= grant_lkp;
            if (grant_lkp) begin
                lkp_id_q <= lkp_flow_id;
            end
            rd_s1_q    <= grant_rd;
            res_valid  <= lkp_s1_q;
            res_hit    <= lkp_s1_q && entry_hit;
            res_action <= (lkp_s1_q && entry_hit) ? ram_rdata.action : '0;
            cfg_wdone  <= grant_wr;
            cfg_rvalid <= rd_s1_q;
            if (rd_s1_q) begin
                cfg_rdata <= unpack_rdata(ram_rdata);
            end
        end
    end

endmodule

// File: tb/tb_action_table_ctrl.sv
// Self-checking bench for action_table_ctrl: behavioural table/arbitration model plus directed
// scenarios. Honours ACTION_CTRL_READBACK_EN the same way as the design.
module tb_action_table_ctrl;

    localparam int DEPTH = 1024;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        lkp_valid, lkp_ready;
    logic [15:0] lkp_flow_id;
    logic        res_valid, res_hit;
    logic [24:0] res_action;
    logic        cfg_we, cfg_wdone, cfg_re, cfg_rvalid, init_done;
    logic [15:0] cfg_waddr, cfg_raddr;
    logic [31:0] cfg_wdata, cfg_rdata;

    always #5 clk = ~clk;

    action_table_ctrl #(
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lkp_valid  (lkp_valid),
        .lkp_ready  (lkp_ready),
        .lkp_flow_id(lkp_flow_id),
        .res_valid  (res_valid),
        .res_hit    (res_hit),
        .res_action (res_action),
        .cfg_we     (cfg_we),
        .cfg_waddr  (cfg_waddr),
        .cfg_wdata  (cfg_wdata),
        .cfg_wdone  (cfg_wdone),
        .cfg_re     (cfg_re),
        .cfg_raddr  (cfg_raddr),
        .cfg_rdata  (cfg_rdata),
        .cfg_rvalid (cfg_rvalid),
        .init_done  (init_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: table contents, arbitration bookkeeping, queues of expected output strobes.
    bit          mv [DEPTH];
    logic [15:0] mf [DEPTH];
    logic [8:0]  mb [DEPTH];
    int          starve;
    int          last_wr, last_rd;
    int          g_last;
    logic        ready_seen;

    typedef struct {int due; logic hit; logic [24:0] act;} res_t;
    typedef struct {int due; logic [31:0] data;} rd_t;
    res_t rq[$];
    int   wq[$];
    rd_t  dq[$];

    logic [15:0] ids [8] = '{16'h0105, 16'h0505, 16'h0010, 16'h0410,
                             16'h03FF, 16'hFFFF, 16'h0000, 16'h8105};

    function automatic logic [15:0] pick_id();
        return ids[$urandom_range(7)];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = 1'b0;
            mf[i] = '0;
            mb[i] = '0;
        end
        rq.delete();
        wq.delete();
        dq.delete();
        starve  = 0;
        last_wr = -100;
        last_rd = -100;
        cyc     = 0;
    endtask

    // One clock: called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic tick();
        bit   run, blanked, re_eff, pend, starved, gl, gw, gr, hit;
        int   idx;
        res_t r;
        rd_t  d;
        #1;
        run     = (cyc >= DEPTH);
        blanked = (cyc <= last_wr + 1) || (cyc <= last_rd + 2);
`ifdef ACTION_CTRL_READBACK_EN
        re_eff = cfg_re;
`else
        re_eff = 1'b0;
`endif
        pend    = (cfg_we || re_eff) && !blanked;
        starved = pend && (starve == LIMIT);
        gl = run && lkp_valid && !starved;
        gw = run && !gl && cfg_we && !blanked;
        gr = run && !gl && !gw && re_eff && !blanked;
        ready_seen = lkp_ready;
        chk("lkp_ready", lkp_ready, gl);
        g_last = gl ? 1 : gw ? 2 : gr ? 3 : 0;
        if (gl) begin
            idx   = lkp_flow_id[9:0];
            hit   = mv[idx] && (mf[idx] == lkp_flow_id);
            r.due = cyc + 2;
            r.hit = hit;
            r.act = hit ? {mf[idx], mb[idx]} : 25'd0;
            rq.push_back(r);
        end
        if (gw) begin
            idx     = cfg_waddr[9:0];
            mv[idx] = !cfg_wdata[31];
            mf[idx] = cfg_waddr;
            mb[idx] = cfg_wdata[8:0];
            wq.push_back(cyc + 1);
            last_wr = cyc;
        end
        if (gr) begin
            idx    = cfg_raddr[9:0];
            d.due  = cyc + 2;
            d.data = {mv[idx], 6'b0, mf[idx], mb[idx]};
            dq.push_back(d);
            last_rd = cyc;
        end
        if (run) begin
            if (gw || gr || !pend) starve = 0;
            else if (gl && starve < LIMIT) starve++;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("init_done", init_done, cyc >= DEPTH);
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            chk("res_valid", res_valid, 1);
            chk("res_hit", res_hit, r.hit);
            chk("res_action", res_action, r.act);
        end else begin
            chk("res_valid", res_valid, 0);
        end
        if (wq.size() > 0 && wq[0] == cyc) begin
            void'(wq.pop_front());
            chk("cfg_wdone", cfg_wdone, 1);
        end else begin
            chk("cfg_wdone", cfg_wdone, 0);
        end
        if (dq.size() > 0 && dq[0].due == cyc) begin
            d = dq.pop_front();
            chk("cfg_rvalid", cfg_rvalid, 1);
            chk("cfg_rdata", cfg_rdata, d.data);
        end else begin
            chk("cfg_rvalid", cfg_rvalid, 0);
        end
`ifndef ACTION_CTRL_READBACK_EN
        chk("cfg_rdata_off", cfg_rdata, 0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_wdone", cfg_wdone, 0);
        chk("rst_rvalid", cfg_rvalid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // INIT with lookups offered and a write held pending throughout.
    task automatic init_phase(input logic [15:0] waddr, input logic [31:0] wdata);
        int first_done = -1;
        int ready_in_init = 0;
        cfg_we    = 1'b1;
        cfg_waddr = waddr;
        cfg_wdata = wdata;
        for (int i = 0; i < DEPTH + 16; i++) begin
            lkp_valid   = $urandom_range(1);
            lkp_flow_id = pick_id();
            tick();
            if (cyc <= DEPTH && ready_seen) ready_in_init++;
            if (init_done && first_done < 0) first_done = cyc;
            if (g_last == 2) cfg_we = 1'b0;
        end
        chk("init_latency", first_done, DEPTH);
        chk("init_ready_low", ready_in_init, 0);
        cfg_we    = 1'b0;
        lkp_valid = 1'b0;
        tick();
    endtask

    task automatic rand_cycles(input int n);
        int op  = 0;
        int rgc = -1;
        for (int i = 0; i < n; i++) begin
            lkp_valid   = ($urandom_range(3) != 0);
            lkp_flow_id = pick_id();
            if (op == 0 && $urandom_range(3) == 0) begin
`ifdef ACTION_CTRL_READBACK_EN
                if ($urandom_range(1) == 0) begin
                    op        = 2;
                    rgc       = -1;
                    cfg_re    = 1'b1;
                    cfg_raddr = pick_id();
                end else
`endif
                begin
                    op            = 1;
                    cfg_we        = 1'b1;
                    cfg_waddr     = pick_id();
                    cfg_wdata     = $urandom;
                    cfg_wdata[31] = ($urandom_range(3) == 0);
                end
            end
`ifndef ACTION_CTRL_READBACK_EN
            cfg_re    = $urandom_range(1);
            cfg_raddr = $urandom;
`endif
            tick();
            if (g_last == 2) begin
                cfg_we = 1'b0;
                op     = 0;
            end
            if (g_last == 3) rgc = cyc - 1;
            if (op == 2 && rgc >= 0 && cyc >= rgc + 2) begin
                cfg_re = 1'b0;
                op     = 0;
            end
        end
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        lkp_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        int first_block;
        int wd;
        int rv;
        lkp_valid   = 1'b0;
        lkp_flow_id = '0;
        cfg_we      = 1'b0;
        cfg_waddr   = '0;
        cfg_wdata   = '0;
        cfg_re      = 1'b0;
        cfg_raddr   = '0;
        #1;
        do_reset();
        init_phase(16'h03FF, 32'h0000_0055);

        // Program 0x0105 (forward, out_port 1), look it up the very next cycle, then an alias.
        cfg_we    = 1'b1;
        cfg_waddr = 16'h0105;
        cfg_wdata = 32'h0000_000A;
        tick();
        chk("wr_wdone_next", cfg_wdone, 1);
        cfg_we      = 1'b0;
        lkp_valid   = 1'b1;
        lkp_flow_id = 16'h0105;
        tick();
        lkp_flow_id = 16'h0505;
        tick();
        chk("hit_valid", res_valid, 1);
        chk("hit_hit", res_hit, 1);
        chk("hit_forward", res_action[1], 1);
        chk("hit_out_port", res_action[6:3], 1);
        chk("hit_action", res_action, 32'h0002_0A0A);
        lkp_valid = 1'b0;
        tick();
        chk("alias_valid", res_valid, 1);
        chk("alias_hit", res_hit, 0);
        chk("alias_action", res_action, 0);
`ifdef ACTION_CTRL_READBACK_EN
        cfg_re    = 1'b1;
        cfg_raddr = 16'h0105;
        tick();
        tick();
        chk("rb_valid", cfg_rvalid, 1);
        chk("rb_data", cfg_rdata, 32'h8002_0A0A);
        cfg_re = 1'b0;
        tick();
`endif

        // Starvation guard: lookups every cycle, write held; write wins on the 9th cycle.
        tick();
        lkp_valid   = 1'b1;
        cfg_we      = 1'b1;
        cfg_waddr   = 16'h0010;
        cfg_wdata   = 32'h0000_0181;
        first_block = -1;
        wd          = 0;
        for (int i = 1; i <= 14; i++) begin
            lkp_flow_id = pick_id();
            tick();
            if (!ready_seen && first_block < 0) first_block = i;
            if (cfg_wdone) wd++;
            if (g_last == 2) cfg_we = 1'b0;
        end
        chk("starve_grant_cycle", first_block, 9);
        chk("starve_wdone_once", wd, 1);
        lkp_valid = 1'b0;
        tick();
        tick();

        // Invalidate 0x0105 and confirm the miss (and readback valid bit clear).
        cfg_we    = 1'b1;
        cfg_waddr = 16'h0105;
        cfg_wdata = 32'h8000_000A;
        tick();
        cfg_we      = 1'b0;
        lkp_valid   = 1'b1;
        lkp_flow_id = 16'h0105;
        tick();
        lkp_valid = 1'b0;
        tick();
        chk("inval_valid", res_valid, 1);
        chk("inval_hit", res_hit, 0);
        chk("inval_action", res_action, 0);
`ifdef ACTION_CTRL_READBACK_EN
        cfg_re    = 1'b1;
        cfg_raddr = 16'h0105;
        tick();
        tick();
        chk("inval_rb_valid", cfg_rvalid, 1);
        chk("inval_rb_bit31", cfg_rdata[31], 0);
        chk("inval_rb_data", cfg_rdata, 32'h0002_0A0A);
        cfg_re = 1'b0;
        tick();
`endif

        rand_cycles(2500);

        // Reset with a lookup in flight: its result must never appear, INIT restarts.
        lkp_valid   = 1'b1;
        lkp_flow_id = 16'h0010;
        tick();
        lkp_valid = 1'b0;
        do_reset();
        rv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid) rv++;
        end
        chk("reset_drop_result", rv, 0);
        chk("reset_init_restart", init_done, 0);
        init_phase(16'h0410, 32'h0000_0031);

        // Table was cleared again: the earlier valid entry at 0x0010 is gone.
        lkp_valid   = 1'b1;
        lkp_flow_id = 16'h0010;
        tick();
        lkp_valid = 1'b0;
        tick();
        chk("cleared_valid", res_valid, 1);
        chk("cleared_hit", res_hit, 0);

        rand_cycles(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
